// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit serializer and the receive path.
package uart_pkg;

   localparam int unsigned UART_WIDTH     = 8;
   localparam int unsigned UART_DIV_WIDTH = 16;
   localparam logic        UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_e;

   // Frame format latched at the start of every frame
   typedef struct packed {
      logic parity_en;
      logic parity_odd;
      logic stop2;
   } uart_cfg_t;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// FIFO read-port handshake between the TX FIFO (slave) and the serializer (master).
interface uart_tx_serializer_if
   import uart_pkg::*;
#(
   parameter int unsigned WIDTH = UART_WIDTH
);

   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_data;
   logic             fifo_rd_en;

   modport master (
      input  fifo_empty,
      input  fifo_data,
      output fifo_rd_en
   );

   modport slave (
      output fifo_empty,
      output fifo_data,
      input  fifo_rd_en
   );

endinterface

// File: rtl/uart_baud_cnt.sv
// Programmable bit-period down-counter; ticks on the last clock of each period.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int unsigned DIV_WIDTH = UART_DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_load,
   input  logic                 i_en,
   input  logic [DIV_WIDTH-1:0] i_load_val,
   output logic                 o_bit_tick_c
);

   logic [DIV_WIDTH-1:0] r_cnt;

   assign o_bit_tick_c = i_en && (r_cnt == DIV_WIDTH'(1));

   // Load value is always >= 1; reload happens at every bit boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load || o_bit_tick_c) begin
         r_cnt <= i_load_val;
      end else if (i_en) begin
         r_cnt <= r_cnt - DIV_WIDTH'(1);
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from a FWFT FIFO and shifts out
// start / data (LSB first) / optional parity / 1-2 stop bits on tx.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int unsigned WIDTH     = UART_WIDTH,
   parameter int unsigned DIV_WIDTH = UART_DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_WIDTH-1:0] baud_div,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 stop2,
   uart_tx_serializer_if.master fifo,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   uart_state_e          r_state;
   logic [WIDTH-1:0]     r_shift;
   logic [IDX_W-1:0]     r_bit_idx;
   logic                 r_stop_idx;
   logic                 r_parity;
   uart_cfg_t            r_cfg;
   logic [DIV_WIDTH-1:0] r_period;
   logic                 r_tx;

   logic                 w_tick;
   logic                 w_last_stop;
   logic                 w_pop;
   logic [DIV_WIDTH-1:0] w_period;
   logic [DIV_WIDTH-1:0] w_load_val;

   assign w_period    = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
   assign w_last_stop = (r_state == ST_STOP) && w_tick && (!r_cfg.stop2 || r_stop_idx);
   assign w_pop       = !rst && !fifo.fifo_empty && ((r_state == ST_IDLE) || w_last_stop);
   assign w_load_val  = w_pop ? w_period : r_period;

   assign fifo.fifo_rd_en = w_pop;
   assign tx              = r_tx;
   assign tx_busy         = (r_state != ST_IDLE);
   assign tx_done         = w_last_stop && !rst;

   uart_baud_cnt #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_baud_cnt (
      .clk          (clk),
      .rst          (rst),
      .i_load       (w_pop),
      .i_en         (r_state != ST_IDLE),
      .i_load_val   (w_load_val),
      .o_bit_tick_c (w_tick)
   );

   // Frame sequencer; r_tx always holds the level for the state being entered
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_tx       <= UART_IDLE_LEVEL;
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_stop_idx <= 1'b0;
         r_parity   <= 1'b0;
         r_cfg      <= '0;
         r_period   <= DIV_WIDTH'(1);
      end else if (w_pop) begin
         r_state          <= ST_START;
         r_tx             <= 1'b0;
         r_shift          <= fifo.fifo_data;
         r_parity         <= (^fifo.fifo_data) ^ parity_odd;
         r_cfg.parity_en  <= parity_en;
         r_cfg.parity_odd <= parity_odd;
         r_cfg.stop2      <= stop2;
         r_period         <= w_period;
         r_bit_idx        <= '0;
         r_stop_idx       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_tx <= UART_IDLE_LEVEL;
            end
            ST_START: begin
               if (w_tick) begin
                  r_state   <= ST_DATA;
                  r_tx      <= r_shift[0];
                  r_bit_idx <= '0;
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  if (r_bit_idx == IDX_W'(WIDTH - 1)) begin
                     if (r_cfg.parity_en) begin
                        r_state <= ST_PARITY;
                        r_tx    <= r_parity;
                     end else begin
                        r_state    <= ST_STOP;
                        r_tx       <= UART_IDLE_LEVEL;
                        r_stop_idx <= 1'b0;
                     end
                  end else begin
                     r_bit_idx <= r_bit_idx + IDX_W'(1);
                     r_shift   <= r_shift >> 1;
                     r_tx      <= r_shift[1];
                  end
               end
            end
            ST_PARITY: begin
               if (w_tick) begin
                  r_state    <= ST_STOP;
                  r_tx       <= UART_IDLE_LEVEL;
                  r_stop_idx <= 1'b0;
               end
            end
            ST_STOP: begin
               if (w_last_stop) begin
                  r_state <= ST_IDLE;
               end else if (w_tick) begin
                  r_stop_idx <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_tx    <= UART_IDLE_LEVEL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: frame-level line model checked every cycle,
// plus literal expectations for lengths, bit levels and pop/done timing.
module tb_uart_tx_serializer;
   import uart_pkg::*;

   localparam int unsigned W  = 8;
   localparam int unsigned DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] baud_div;
   logic          parity_en;
   logic          parity_odd;
   logic          stop2;
   logic          tx;
   logic          tx_busy;
   logic          tx_done;

   uart_tx_serializer_if #(.WIDTH(W)) bus ();

   uart_tx_serializer #(
      .WIDTH     (W),
      .DIV_WIDTH (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .baud_div   (baud_div),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .stop2      (stop2),
      .fifo       (bus),
      .tx         (tx),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done)
   );

   always #5 clk = ~clk;

   int           n_checks = 0;
   int           n_fail   = 0;
   int           cyc      = 0;
   logic [W-1:0] fifo_q[$];
   logic         m_line[$];
   logic         tx_log[$];
   int           pop_cyc[$];
   int           done_cyc[$];
   logic         pend_pop;
   logic         e_tx, e_busy, e_done, e_rd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Expected line level for every clock of one frame, from the current config
   task automatic build_frame(input logic [W-1:0] b);
      int   per;
      logic bits[$];
      per = (baud_div == '0) ? 1 : int'(baud_div);
      bits.push_back(1'b0);
      for (int i = 0; i < int'(W); i++) bits.push_back(b[i]);
      if (parity_en) bits.push_back((^b) ^ parity_odd);
      bits.push_back(1'b1);
      if (stop2) bits.push_back(1'b1);
      foreach (bits[k]) begin
         for (int r = 0; r < per; r++) m_line.push_back(bits[k]);
      end
   endtask

   // Per-cycle compare against the model, then advance the model
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         check("rd_during_reset", 32'(bus.fifo_rd_en), 0);
         check("done_during_reset", 32'(tx_done), 0);
         m_line.delete();
      end else begin
         if (m_line.size() == 0) begin
            e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_rd = !bus.fifo_empty;
         end else begin
            e_tx   = m_line[0];
            e_busy = 1'b1;
            e_done = (m_line.size() == 1);
            e_rd   = e_done && !bus.fifo_empty;
         end
         check("model_tx", 32'(tx), 32'(e_tx));
         check("model_busy", 32'(tx_busy), 32'(e_busy));
         check("model_done", 32'(tx_done), 32'(e_done));
         check("model_rd", 32'(bus.fifo_rd_en), 32'(e_rd));
         if (m_line.size() != 0) void'(m_line.pop_front());
         if (e_rd) build_frame(bus.fifo_data);
      end
      if (tx_busy) tx_log.push_back(tx);
      if (bus.fifo_rd_en === 1'b1) begin
         pop_cyc.push_back(cyc);
         pend_pop = 1'b1;
      end
      if (tx_done === 1'b1) done_cyc.push_back(cyc);
   end

   // FWFT FIFO read side: pop the head after a strobed edge
   always @(posedge clk) begin
      #2;
      if (pend_pop) begin
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
         pend_pop = 1'b0;
      end
      bus.fifo_empty = (fifo_q.size() == 0);
      bus.fifo_data  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
   end

   task automatic start_test(input int div, input logic pen, input logic podd, input logic s2);
      @(posedge clk); #1;
      baud_div   = DW'(div);
      parity_en  = pen;
      parity_odd = podd;
      stop2      = s2;
      tx_log.delete();
      pop_cyc.delete();
      done_cyc.delete();
   endtask

   task automatic run_idle(input string name, input int max_cyc);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((fifo_q.size() != 0 || tx_busy) && n < max_cyc);
      check(name, 32'(n < max_cyc), 1);
   endtask

   // Line level sampled mid-bit for a 10-bit 8N1 frame
   task automatic check_line(input string name, input logic [9:0] lit, input int per);
      for (int i = 0; i < 10; i++) check(name, 32'(tx_log[i*per + per/2]), 32'(lit[i]));
   endtask

   initial begin
      rst = 1'b1; baud_div = DW'(4); parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
      bus.fifo_empty = 1'b1; bus.fifo_data = '0; pend_pop = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_tx", 32'(tx), 1);
      check("reset_busy", 32'(tx_busy), 0);
      check("reset_done", 32'(tx_done), 0);
      check("reset_rd", 32'(bus.fifo_rd_en), 0);

      // 8N1, period 4, 0x55
      start_test(4, 1'b0, 1'b0, 1'b0);
      fifo_q.push_back(8'h55);
      run_idle("t1_timeout", 200);
      check("t1_pops", pop_cyc.size(), 1);
      check("t1_dones", done_cyc.size(), 1);
      check("t1_len", 32'(done_cyc[0] - pop_cyc[0]), 40);
      check("t1_busy_clocks", tx_log.size(), 40);
      check_line("t1_bit", 10'h2AA, 4);

      // even parity, period 3, 0x07
      start_test(3, 1'b1, 1'b0, 1'b0);
      fifo_q.push_back(8'h07);
      run_idle("t2_timeout", 200);
      check("t2_len", 32'(done_cyc[0] - pop_cyc[0]), 33);
      check("t2_parity", 32'(tx_log[9*3 + 1]), 1);
      check("t2_stop", 32'(tx_log[10*3 + 1]), 1);

      // odd parity, same byte
      start_test(3, 1'b1, 1'b1, 1'b0);
      fifo_q.push_back(8'h07);
      run_idle("t3_timeout", 200);
      check("t3_len", 32'(done_cyc[0] - pop_cyc[0]), 33);
      check("t3_parity", 32'(tx_log[9*3 + 1]), 0);

      // back-to-back, two stop bits, period 2
      start_test(2, 1'b0, 1'b0, 1'b1);
      fifo_q.push_back(8'hA5);
      fifo_q.push_back(8'h3C);
      run_idle("t4_timeout", 300);
      check("t4_pops", pop_cyc.size(), 2);
      check("t4_dones", done_cyc.size(), 2);
      check("t4_len0", 32'(done_cyc[0] - pop_cyc[0]), 22);
      check("t4_len1", 32'(done_cyc[1] - pop_cyc[1]), 22);
      check("t4_pop_at_done", 32'(pop_cyc[1] - done_cyc[0]), 0);
      check("t4_busy_clocks", tx_log.size(), 44);
      check("t4_last_stop", 32'(tx_log[21]), 1);
      check("t4_second_start", 32'(tx_log[22]), 0);

      // divisor 0 behaves as 1
      start_test(0, 1'b0, 1'b0, 1'b0);
      fifo_q.push_back(8'hFF);
      run_idle("t5_timeout", 100);
      check("t5_len", 32'(done_cyc[0] - pop_cyc[0]), 10);
      check("t5_busy_clocks", tx_log.size(), 10);
      check_line("t5_bit", 10'h3FE, 1);

      // reset during data bit 3 of 0x81, then a clean 0x42
      start_test(4, 1'b0, 1'b0, 1'b0);
      fifo_q.push_back(8'h81);
      begin
         int n = 0;
         while (tx_log.size() < 17 && n < 500) begin
            @(negedge clk);
            n++;
         end
         check("t6_reach_bit3", 32'(n < 500), 1);
      end
      check("t6_bit3_level", 32'(tx_log[16]), 0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("t6_tx_after_reset", 32'(tx), 1);
      check("t6_busy_after_reset", 32'(tx_busy), 0);
      check("t6_no_done", done_cyc.size(), 0);
      start_test(4, 1'b0, 1'b0, 1'b0);
      fifo_q.push_back(8'h42);
      run_idle("t6_timeout", 200);
      check("t6_pops", pop_cyc.size(), 1);
      check("t6_len", 32'(done_cyc[0] - pop_cyc[0]), 40);
      check_line("t6_bit", 10'h284, 4);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
